// File: rtl/counter_seq_ctrl.sv
// Sequencer for an external up-counter: captures limit/prescale on start, drives
// clear/enable, flags terminal count, and supports one-shot or auto-reload runs.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; counter left as-is
//   S_CLEAR | one cycle clearing the counter, prescaler rearmed
//   S_RUN   | prescaled enables until the counter reaches limit_q
//   S_DONE  | one-shot finished; done held until the next start or stop
module counter_seq_ctrl #(
  parameter int N_BITS     = 8,
  parameter int PRESC_BITS = 4
) (
  input  logic                  clk,
  input  logic                  syn_rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  periodic,
  input  logic [N_BITS-1:0]     cfg_limit,
  input  logic [PRESC_BITS-1:0] cfg_presc,
  input  logic [N_BITS-1:0]     cnt_value,
  output logic                  cnt_clr,
  output logic                  cnt_en,
  output logic                  tc_pulse,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state, state_d;
  logic [PRESC_BITS-1:0] presc_q, presc_d;
  logic [PRESC_BITS-1:0] presc_cfg_q;
  logic [N_BITS-1:0]     limit_q;
  logic                  periodic_q;
  logic                  load_cfg;
  logic                  tick;
  logic                  at_limit;

  always_ff @(posedge clk) begin
    if (syn_rst) begin
      state       <= S_IDLE;
      presc_q     <= '0;
      limit_q     <= '0;
      presc_cfg_q <= '0;
      periodic_q  <= 1'b0;
    end else begin
      state   <= state_d;
      presc_q <= presc_d;
      if (load_cfg) begin
        limit_q     <= cfg_limit;
        presc_cfg_q <= cfg_presc;
        periodic_q  <= periodic;
      end
    end
  end

  // stop masks every strobe in the cycle it is seen, including the CLEAR pulse
  always_comb begin
    tick     = (state == S_RUN) && (presc_q == presc_cfg_q) && !pause && !stop;
    at_limit = (cnt_value == limit_q);
    cnt_en   = tick && !at_limit;
    tc_pulse = tick && at_limit;
    cnt_clr  = ((state == S_CLEAR) && !stop) || (tc_pulse && periodic_q);
    busy     = (state == S_CLEAR) || (state == S_RUN);
    done     = (state == S_DONE);
  end

  always_comb begin
    state_d  = state;
    presc_d  = presc_q;
    load_cfg = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d  = S_CLEAR;
            load_cfg = 1'b1;
          end
        end
        S_CLEAR: begin
          state_d = S_RUN;
          presc_d = '0;
        end
        S_RUN: begin
          if (!pause) begin
            if (tick) begin
              presc_d = '0;
              if (tc_pulse && !periodic_q) state_d = S_DONE;
            end else begin
              presc_d = presc_q + PRESC_BITS'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural model of the controlled counter.
// Output vector order in checks: {cnt_clr, cnt_en, tc_pulse, busy, done}.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       syn_rst;
  logic       start, stop, pause, periodic;
  logic [7:0] cfg_limit;
  logic [3:0] cfg_presc;
  logic [7:0] cnt_value;
  logic       cnt_clr, cnt_en, tc_pulse, busy, done;

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_seq_ctrl #(.N_BITS(8), .PRESC_BITS(4)) dut (
    .clk(clk), .syn_rst(syn_rst), .start(start), .stop(stop), .pause(pause),
    .periodic(periodic), .cfg_limit(cfg_limit), .cfg_presc(cfg_presc),
    .cnt_value(cnt_value), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
    .tc_pulse(tc_pulse), .busy(busy), .done(done)
  );

  // the controlled counter
  always @(posedge clk) begin
    if (syn_rst || cnt_clr) cnt_value <= 8'd0;
    else if (cnt_en)        cnt_value <= cnt_value + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // call once per cycle, after this cycle's inputs are applied
  task automatic outs(input string tag, input logic [4:0] exp);
    #1;
    chk(tag, {cnt_clr, cnt_en, tc_pulse, busy, done}, exp);
  endtask

  task automatic go(input logic [7:0] lim, input logic [3:0] pr, input logic per);
    start = 1'b1; cfg_limit = lim; cfg_presc = pr; periodic = per;
  endtask

  initial begin
    logic [4:0] exp_v;
    syn_rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; periodic = 1'b0;
    cfg_limit = 8'd0; cfg_presc = 4'd0;
    cyc();
    outs("reset_outs", 5'b00000);
    cyc();
    syn_rst = 1'b0;
    outs("idle_outs", 5'b00000);

    // 1: one-shot, limit=3 presc=0
    cyc(); go(8'd3, 4'd0, 1'b0); outs("t1_c0", 5'b00000);
    cyc(); start = 1'b0; cfg_limit = 8'd9; outs("t1_c1", 5'b10010);
    cyc(); outs("t1_c2", 5'b01010);
    cyc(); outs("t1_c3", 5'b01010);
    cyc(); outs("t1_c4", 5'b01010);
    cyc(); outs("t1_c5", 5'b00110);
    chk("t1_cnt_c5", cnt_value, 8'd3);
    cyc(); outs("t1_c6", 5'b00001);
    cyc(); outs("t1_c7", 5'b00001);

    // 2: periodic, limit=2 presc=1 -> 6-cycle period
    go(8'd2, 4'd1, 1'b1); outs("t2_c0", 5'b00001);
    cyc(); start = 1'b0; outs("t2_c1", 5'b10010);
    for (int c = 2; c < 14; c++) begin
      int k;
      k = (c - 2) % 6;
      cyc();
      case (k)
        1, 3:    exp_v = 5'b01010;
        5:       exp_v = 5'b10110;
        default: exp_v = 5'b00010;
      endcase
      outs($sformatf("t2_c%0d", c), exp_v);
      chk($sformatf("t2_cnt_c%0d", c), cnt_value, 32'(k / 2));
    end
    cyc(); stop = 1'b1; outs("t2_stop", 5'b00010);
    cyc(); stop = 1'b0; outs("t2_idle", 5'b00000);

    // 3: pause for 4 cycles in RUN, limit=3 presc=0
    cyc(); go(8'd3, 4'd0, 1'b0); outs("t3_c0", 5'b00000);
    cyc(); start = 1'b0; outs("t3_c1", 5'b10010);
    cyc(); outs("t3_c2", 5'b01010);
    for (int c = 3; c < 7; c++) begin
      cyc(); pause = 1'b1;
      outs($sformatf("t3_pause_c%0d", c), 5'b00010);
      chk($sformatf("t3_cnt_c%0d", c), cnt_value, 8'd1);
    end
    cyc(); pause = 1'b0; outs("t3_c7", 5'b01010);
    cyc(); outs("t3_c8", 5'b01010);
    cyc(); outs("t3_c9", 5'b00110);
    cyc(); outs("t3_c10", 5'b00001);

    // 4: stop and start together in RUN
    go(8'd5, 4'd0, 1'b0); outs("t4_c0", 5'b00001);
    cyc(); start = 1'b0; outs("t4_c1", 5'b10010);
    cyc(); outs("t4_c2", 5'b01010);
    cyc(); outs("t4_c3", 5'b01010);
    cyc(); stop = 1'b1; start = 1'b1; outs("t4_c4", 5'b00010);
    cyc(); stop = 1'b0; start = 1'b0; outs("t4_c5", 5'b00000);
    chk("t4_cnt_c5", cnt_value, 8'd2);
    cyc(); outs("t4_c6", 5'b00000);
    chk("t4_cnt_c6", cnt_value, 8'd2);

    // 5: limit=0 presc=2 one-shot, then restart from DONE
    go(8'd0, 4'd2, 1'b0); outs("t5_c0", 5'b00000);
    cyc(); start = 1'b0; outs("t5_c1", 5'b10010);
    cyc(); outs("t5_c2", 5'b00010);
    cyc(); outs("t5_c3", 5'b00010);
    cyc(); outs("t5_c4", 5'b00110);
    cyc(); go(8'd1, 4'd0, 1'b0); outs("t5_c5", 5'b00001);
    cyc(); start = 1'b0; outs("t5_c6", 5'b10010);
    cyc(); outs("t5_c7", 5'b01010);
    cyc(); outs("t5_c8", 5'b00110);
    cyc(); outs("t5_c9", 5'b00001);

    // 6: start ignored in RUN, then reset mid-RUN; limit=4 presc=0 periodic
    go(8'd4, 4'd0, 1'b1); outs("t6_c0", 5'b00001);
    cyc(); start = 1'b0; outs("t6_c1", 5'b10010);
    cyc(); outs("t6_c2", 5'b01010);
    cyc(); go(8'd1, 4'd3, 1'b0); outs("t6_c3", 5'b01010);
    cyc(); start = 1'b0; outs("t6_c4", 5'b01010);
    chk("t6_cnt_c4", cnt_value, 8'd2);
    cyc(); outs("t6_c5", 5'b01010);
    cyc(); outs("t6_c6", 5'b10110);
    cyc(); syn_rst = 1'b1; outs("t6_c7", 5'b01010);
    cyc(); syn_rst = 1'b0; outs("t6_rst", 5'b00000);
    cyc(); outs("t6_after", 5'b00000);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
